// File: rtl/chip8_alu_sequencer.sv
// CHIP-8 8XYN arithmetic/logic sequencer: reads Vx/Vy, drives an external ALU,
// writes the result to Vx and the flag to VF over a fixed six-state schedule.
package chip8_alu_pkg;
    typedef enum logic [2:0] {
        ALU_f_NOP    = 3'd0,
        ALU_f_OR     = 3'd1,
        ALU_f_AND    = 3'd2,
        ALU_f_XOR    = 3'd3,
        ALU_f_ADD    = 3'd4,
        ALU_f_MINUS  = 3'd5,
        ALU_f_RSHIFT = 3'd6,
        ALU_f_LSHIFT = 3'd7
    } alu_f_t;
endpackage

module chip8_alu_sequencer
    import chip8_alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] opcode,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic [3:0]  rd_addr_x,
    output logic [3:0]  rd_addr_y,
    input  logic [7:0]  rd_data_x,
    input  logic [7:0]  rd_data_y,
    output logic [15:0] alu_in1,
    output logic [15:0] alu_in2,
    output alu_f_t      alu_sel,
    input  logic [15:0] alu_out,
    input  logic        alu_carry,
    output logic        wr_en,
    output logic [3:0]  wr_addr,
    output logic [7:0]  wr_data
);

    typedef enum logic [2:0] {IDLE, READ, EXEC, WB_VX, WB_VF, DONE} state_e;

    state_e      state_q, state_d;
    logic [15:0] opcode_q, opcode_d;
    logic [7:0]  result_q, result_d;
    logic        flag_q, flag_d;

    logic [3:0]  n_op;
    logic        legal;
    logic        has_flag;
    logic [15:0] vx16, vy16;
    logic        unused_bits;

    assign n_op     = opcode_q[3:0];
    assign legal    = (opcode_q[15:12] == 4'h8) && ((n_op <= 4'h7) || (n_op == 4'hE));
    assign has_flag = (n_op inside {4'h4, 4'h5, 4'h6, 4'h7, 4'hE});
    assign vx16     = {8'h00, rd_data_x};
    assign vy16     = {8'h00, rd_data_y};
    assign unused_bits = ^{alu_carry, alu_out[14:9]};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            opcode_q <= 16'h0000;
            result_q <= 8'h00;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            result_q <= result_d;
            flag_q   <= flag_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        result_d  = result_q;
        flag_d    = flag_q;
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        illegal   = (state_q == DONE) && !legal;
        rd_addr_x = 4'h0;
        rd_addr_y = 4'h0;
        alu_in1   = 16'h0000;
        alu_in2   = 16'h0000;
        alu_sel   = ALU_f_NOP;
        wr_en     = 1'b0;
        wr_addr   = 4'h0;
        wr_data   = 8'h00;

        case (state_q)
            IDLE: begin
                if (start) begin
                    opcode_d = opcode;
                    state_d  = READ;
                end
            end
            READ: begin
                rd_addr_x = opcode_q[11:8];
                rd_addr_y = opcode_q[7:4];
                state_d   = EXEC;
            end
            EXEC: begin
                rd_addr_x = opcode_q[11:8];
                rd_addr_y = opcode_q[7:4];
                if (legal) begin
                    alu_in1  = vx16;
                    alu_in2  = vy16;
                    result_d = alu_out[7:0];
                    flag_d   = 1'b0;
                    case (n_op)
                        4'h0: result_d = rd_data_y;
                        4'h1: alu_sel = ALU_f_OR;
                        4'h2: alu_sel = ALU_f_AND;
                        4'h3: alu_sel = ALU_f_XOR;
                        4'h4: begin
                            alu_sel = ALU_f_ADD;
                            flag_d  = alu_out[8];
                        end
                        4'h5: begin
                            alu_sel = ALU_f_MINUS;
                            flag_d  = ~alu_out[15];
                        end
                        4'h7: begin
                            alu_sel = ALU_f_MINUS;
                            alu_in1 = vy16;
                            alu_in2 = vx16;
                            flag_d  = ~alu_out[15];
                        end
                        4'h6: begin
                            alu_sel = ALU_f_RSHIFT;
                            alu_in2 = 16'h0001;
                            flag_d  = rd_data_x[0];
                        end
                        4'hE: begin
                            alu_sel = ALU_f_LSHIFT;
                            alu_in2 = 16'h0001;
                            flag_d  = rd_data_x[7];
                        end
                        default: ;
                    endcase
                    state_d = WB_VX;
                end else begin
                    state_d = DONE;
                end
            end
            WB_VX: begin
                wr_en   = 1'b1;
                wr_addr = opcode_q[11:8];
                wr_data = result_q;
                state_d = WB_VF;
            end
            WB_VF: begin
                // Flag write comes last so it wins when X is F.
                if (has_flag) begin
                    wr_en   = 1'b1;
                    wr_addr = 4'hF;
                    wr_data = {7'b0, flag_q};
                end
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_chip8_alu_sequencer.sv
// Self-checking bench: register-file and ALU models around the sequencer,
// expected writes queued at stimulus time and matched as the DUT writes.
module tb_chip8_alu_sequencer;
    import chip8_alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] opcode = 16'h0000;
    logic        busy, done, illegal;
    logic [3:0]  rd_addr_x, rd_addr_y;
    logic [7:0]  rd_data_x = 8'h00, rd_data_y = 8'h00;
    logic [15:0] alu_in1, alu_in2, alu_out;
    alu_f_t      alu_sel;
    logic        alu_carry;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;

    logic [7:0]  rf [16];
    logic        pl_en = 1'b0;
    logic [3:0]  pl_addr = 4'h0;
    logic [7:0]  pl_data = 8'h00;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
        int         cyc;
    } wr_t;
    wr_t sb[$];

    int n_checks = 0;
    int n_fails  = 0;

    chip8_alu_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .opcode(opcode),
        .busy(busy), .done(done), .illegal(illegal),
        .rd_addr_x(rd_addr_x), .rd_addr_y(rd_addr_y),
        .rd_data_x(rd_data_x), .rd_data_y(rd_data_y),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_carry(alu_carry),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    // Register file: read data one cycle after address; DUT writes win over preload.
    always @(posedge clk) begin
        rd_data_x <= rf[rd_addr_x];
        rd_data_y <= rf[rd_addr_y];
        if (wr_en)      rf[wr_addr] <= wr_data;
        else if (pl_en) rf[pl_addr] <= pl_data;
    end

    always_comb begin
        alu_out   = 16'h0000;
        alu_carry = 1'b0;
        case (alu_sel)
            ALU_f_OR:     alu_out = alu_in1 | alu_in2;
            ALU_f_AND:    alu_out = alu_in1 & alu_in2;
            ALU_f_XOR:    alu_out = alu_in1 ^ alu_in2;
            ALU_f_ADD:    {alu_carry, alu_out} = {1'b0, alu_in1} + {1'b0, alu_in2};
            ALU_f_MINUS:  alu_out = alu_in1 - alu_in2;
            ALU_f_RSHIFT: alu_out = alu_in1 >> alu_in2[3:0];
            ALU_f_LSHIFT: alu_out = alu_in1 << alu_in2[3:0];
            default:      alu_out = 16'h0000;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    // Architectural reference for 8XYN, independent of the ALU encoding.
    task automatic ref_op(input logic [15:0] op, input logic [7:0] vx, input logic [7:0] vy,
                          output bit legal, output bit hasf, output logic [7:0] res,
                          output bit f, output alu_f_t sel);
        logic [8:0] sum;
        legal = (op[15:12] == 4'h8);
        hasf  = 1'b0;
        res   = 8'h00;
        f     = 1'b0;
        sel   = ALU_f_NOP;
        case (op[3:0])
            4'h0: res = vy;
            4'h1: begin res = vx | vy; sel = ALU_f_OR;  end
            4'h2: begin res = vx & vy; sel = ALU_f_AND; end
            4'h3: begin res = vx ^ vy; sel = ALU_f_XOR; end
            4'h4: begin sum = {1'b0, vx} + {1'b0, vy}; res = sum[7:0]; f = sum[8];
                        hasf = 1'b1; sel = ALU_f_ADD; end
            4'h5: begin res = vx - vy; f = (vx >= vy); hasf = 1'b1; sel = ALU_f_MINUS; end
            4'h7: begin res = vy - vx; f = (vy >= vx); hasf = 1'b1; sel = ALU_f_MINUS; end
            4'h6: begin res = vx >> 1; f = vx[0]; hasf = 1'b1; sel = ALU_f_RSHIFT; end
            4'hE: begin res = vx << 1; f = vx[7]; hasf = 1'b1; sel = ALU_f_LSHIFT; end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            hasf = 1'b0;
            sel  = ALU_f_NOP;
        end
    endtask

    task automatic run_op(input logic [15:0] op, input bit hold);
        bit     legal, hasf, f;
        logic [7:0] res;
        alu_f_t sel;
        wr_t    e;
        int     done_c;
        int     last;
        ref_op(op, rf[op[11:8]], rf[op[7:4]], legal, hasf, res, f, sel);
        if (legal) begin
            e.addr = op[11:8]; e.data = res; e.cyc = 3;
            sb.push_back(e);
            if (hasf) begin
                e.addr = 4'hF; e.data = {7'b0, f}; e.cyc = 4;
                sb.push_back(e);
            end
        end
        done_c = legal ? 5 : 3;
        last   = hold ? 8 : 6;
        @(negedge clk);
        opcode = op;
        start  = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            if (c == 1) opcode = 16'($urandom);
            if (!hold && c == 1) start = 1'b0;
            if (hold && c == 5)  start = 1'b0;
            check("busy", busy, 32'(c <= done_c));
            check("done", done, 32'(c == done_c));
            check("illegal", illegal, 32'(!legal && c == done_c));
            check("alu_sel", alu_sel, (c == 2) ? sel : ALU_f_NOP);
            if (c == 1 || c == 2) begin
                check("rd_addr_x", rd_addr_x, op[11:8]);
                check("rd_addr_y", rd_addr_y, op[7:4]);
            end
            if (wr_en) begin
                if (sb.size() == 0) begin
                    check("spurious_wr", wr_en, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check("wr_addr", wr_addr, e.addr);
                    check("wr_data", wr_data, e.data);
                    check("wr_cycle", c, e.cyc);
                end
            end
        end
        check("writes_drained", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        logic [3:0] x, y, n, top;
        logic [7:0] vf_before;

        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_illegal", illegal, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_rd_addr", {rd_addr_x, rd_addr_y}, 0);
        check("rst_alu_in", {alu_in1, alu_in2}, 0);
        check("rst_alu_sel", alu_sel, ALU_f_NOP);
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) preload(4'(i), 8'h00);

        // ADD with carry
        preload(4'h3, 8'hC8);
        preload(4'h4, 8'h64);
        run_op(16'h8344, 1'b0);
        check("add_v3", rf[3], 8'h2C);
        check("add_vf", rf[15], 8'h01);

        // SUBN then SUB
        preload(4'h1, 8'h10);
        preload(4'h2, 8'h20);
        run_op(16'h8127, 1'b0);
        check("subn_v1", rf[1], 8'h10);
        check("subn_vf", rf[15], 8'h01);
        run_op(16'h8125, 1'b0);
        check("sub_v1", rf[1], 8'hF0);
        check("sub_vf", rf[15], 8'h00);

        // Shift left with X=F: flag write overrides result
        preload(4'hF, 8'h81);
        run_op(16'h8F0E, 1'b0);
        check("shl_vf_final", rf[15], 8'h01);

        // Illegal N and illegal major opcode
        run_op(16'h8AB9, 1'b0);
        run_op(16'h1234, 1'b0);

        // OR with start held high while busy
        preload(4'h5, 8'h0F);
        preload(4'h6, 8'hF0);
        vf_before = rf[15];
        run_op(16'h8561, 1'b1);
        check("or_v5", rf[5], 8'hFF);
        check("or_vf_untouched", rf[15], vf_before);

        // Random mix of operations and registers
        for (int i = 0; i < 16; i++) begin
            x   = 4'($urandom_range(15));
            y   = 4'($urandom_range(15));
            n   = 4'($urandom_range(15));
            top = ($urandom_range(7) == 0) ? 4'h2 : 4'h8;
            preload(x, 8'($urandom));
            preload(y, 8'($urandom));
            run_op({top, x, y, n}, 1'b0);
        end

        // Abort during WB_VX
        preload(4'h1, 8'h33);
        preload(4'h2, 8'h44);
        preload(4'hF, 8'h5A);
        @(negedge clk);
        opcode = 16'h8124;
        start  = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("abort_wb_active", wr_en, 1);
        #1 reset_n = 1'b0;
        #1;
        check("abort_wr_en", wr_en, 0);
        check("abort_busy", busy, 0);
        check("abort_wr_addr", wr_addr, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("abort_no_wr", wr_en, 0);
        end
        check("abort_v1", rf[1], 8'h33);
        check("abort_vf", rf[15], 8'h5A);
        run_op(16'h8124, 1'b0);
        check("post_abort_v1", rf[1], 8'h77);
        check("post_abort_vf", rf[15], 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
